// File: rtl/accel_sketch_debug_host_pkg.sv
// Shared definitions for the Nios II virtual-JTAG debug host.
//
// Contents:
//   state_t           sequencer states (IDLE, UIR, CDR, SDR, UDR, RTI, RSP)
//   IR_* constants    virtual IR codes understood by the CPU debug slave
//   DEFAULT_DR_WIDTH  data register length of the debug slave
package accel_sketch_debug_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5,
        ST_RSP  = 3'd6
    } state_t;

    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    localparam int DEFAULT_DR_WIDTH = 38;

endpackage

// File: rtl/accel_sketch_debug_host_tck_gen.sv
// TCK generator for the virtual-JTAG debug host.
//
// While enable is high a half-period counter runs 0..TCK_DIV-1 and tck
// toggles on the terminal count, so one tck period is 2*TCK_DIV clk cycles
// and always starts low. While enable is low the counter and tck are held
// at zero, so the first period after enabling starts cleanly.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   enable   run the generator
//   tck      registered TCK
//   rise     high in the cycle whose closing clk edge drives tck 0->1
//   fall     high in the cycle whose closing clk edge drives tck 1->0
module accel_sketch_debug_host_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TCK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             terminal;

    assign terminal = enable && (cnt_reg == CNT_LAST);
    assign rise     = terminal && !tck;
    assign fall     = terminal && tck;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
            tck     <= 1'b0;
        end else if (!enable) begin
            cnt_reg <= '0;
            tck     <= 1'b0;
        end else if (terminal) begin
            cnt_reg <= '0;
            tck     <= ~tck;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/accel_sketch_nios2_gen2_0_cpu_debug_host.sv
// Initiator end of the Nios II virtual-JTAG debug channel.
//
// Accepts a parallel command (virtual IR code + DR word), plays it to the
// CPU debug slave as a virtual JTAG sequence UIR -> CDR -> SDR x DR_WIDTH ->
// UDR -> RTI x RTI_CYCLES, captures tdo into a parallel word and holds it
// as a response until consumed. Every state lasts whole tck periods and
// state changes happen on tck falls, so tck is low at each boundary.
//
// Optional build macro DEBUG_HOST_IR_SKIP_EN: when defined, a command whose
// IR matches the IR already loaded into the slave skips the UIR period.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   cmd_valid/ready/ir/data  command handshake; cmd_data shifted LSB first
//   rsp_valid/ready/data     response handshake; bit i = i-th tdo sample
//   vji_tck/tdi/tdo          virtual JTAG serial signals
//   vji_ir_in                virtual IR presented to the slave
//   vji_uir/cdr/sdr/udr/rti  state strobes, high exactly in that state
module accel_sketch_nios2_gen2_0_cpu_debug_host
    import accel_sketch_debug_host_pkg::*;
#(
    parameter int DR_WIDTH   = DEFAULT_DR_WIDTH,
    parameter int IR_WIDTH   = 2,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam int RTI_W = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);
    localparam logic [RTI_W-1:0] RTI_LAST = RTI_W'((RTI_CYCLES > 0) ? RTI_CYCLES - 1 : 0);

    state_t              state_reg, state_next;
    logic [DR_WIDTH-1:0] tx_reg, tx_next;
    logic [DR_WIDTH-1:0] rx_reg;
    logic [BIT_W-1:0]    bit_cnt_reg;
    logic [RTI_W-1:0]    rti_cnt_reg;
    logic                tck_en;
    logic                rise;
    logic                fall;
    logic                accept;
    logic                skip_uir;

    assign accept = cmd_valid && cmd_ready;
    assign tck_en = (state_reg != ST_IDLE) && (state_reg != ST_RSP);

    accel_sketch_debug_host_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (tck_en),
        .tck     (vji_tck),
        .rise    (rise),
        .fall    (fall)
    );

`ifdef DEBUG_HOST_IR_SKIP_EN
    // Set once the slave has seen an update-IR; vji_ir_in then mirrors the
    // slave's loaded IR, so an identical IR needs no second UIR.
    logic last_ir_valid_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_ir_valid_reg <= 1'b0;
        end else if ((state_reg == ST_UIR) && (state_next != ST_UIR)) begin
            last_ir_valid_reg <= 1'b1;
        end
    end

    assign skip_uir = last_ir_valid_reg && (cmd_ir == vji_ir_in);
`else
    assign skip_uir = 1'b0;
`endif

    // Active states advance only on a tck fall, i.e. at a period end.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = skip_uir ? ST_CDR : ST_UIR;
            ST_UIR:  if (fall) state_next = ST_CDR;
            ST_CDR:  if (fall) state_next = ST_SDR;
            ST_SDR:  if (fall && (bit_cnt_reg == BIT_LAST)) state_next = ST_UDR;
            ST_UDR:  if (fall) state_next = (RTI_CYCLES == 0) ? ST_RSP : ST_RTI;
            ST_RTI:  if (fall && (rti_cnt_reg == RTI_LAST)) state_next = ST_RSP;
            ST_RSP:  if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The transmit word shifts at every SDR period end so tx[0] is always
    // the bit to present during the following period.
    always_comb begin
        tx_next = tx_reg;
        if (accept) begin
            tx_next = cmd_data;
        end else if ((state_reg == ST_SDR) && fall) begin
            tx_next = tx_reg >> 1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            tx_reg      <= '0;
            rx_reg      <= '0;
            bit_cnt_reg <= '0;
            rti_cnt_reg <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            vji_tdi     <= 1'b0;
            vji_ir_in   <= '0;
            vji_uir     <= 1'b0;
            vji_cdr     <= 1'b0;
            vji_sdr     <= 1'b0;
            vji_udr     <= 1'b0;
            vji_rti     <= 1'b0;
        end else begin
            state_reg <= state_next;
            tx_reg    <= tx_next;

            // Outputs are registered from the next state so they line up
            // exactly with the state register.
            cmd_ready <= (state_next == ST_IDLE);
            rsp_valid <= (state_next == ST_RSP);
            vji_uir   <= (state_next == ST_UIR);
            vji_cdr   <= (state_next == ST_CDR);
            vji_sdr   <= (state_next == ST_SDR);
            vji_udr   <= (state_next == ST_UDR);
            vji_rti   <= (state_next == ST_RTI);
            vji_tdi   <= (state_next == ST_SDR) ? tx_next[0] : 1'b0;

            if (accept) begin
                vji_ir_in   <= cmd_ir;
                bit_cnt_reg <= '0;
                rti_cnt_reg <= '0;
            end

            // tdo enters at the top; after DR_WIDTH samples the first one
            // has reached bit 0.
            if ((state_reg == ST_SDR) && rise) begin
                rx_reg <= {vji_tdo, rx_reg[DR_WIDTH-1:1]};
            end

            if ((state_reg == ST_SDR) && fall && (bit_cnt_reg != BIT_LAST)) begin
                bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
            end

            if ((state_reg == ST_RTI) && fall && (rti_cnt_reg != RTI_LAST)) begin
                rti_cnt_reg <= rti_cnt_reg + RTI_W'(1);
            end

            if ((state_reg != ST_RSP) && (state_next == ST_RSP)) begin
                rsp_data <= rx_reg;
            end
        end
    end

endmodule

// File: tb/tb_accel_sketch_nios2_gen2_0_cpu_debug_host.sv
module tb_accel_sketch_nios2_gen2_0_cpu_debug_host;
    import accel_sketch_debug_host_pkg::*;

    localparam int DR        = 38;
    localparam int CLK_NS    = 10;
    localparam int TCK_DIV_A = 2;
    localparam int RTI_A     = 2;
    localparam int TCK_DIV_B = 1;
    localparam int RTI_B     = 0;
    localparam int LAT_LIMIT = 1000;
`ifdef DEBUG_HOST_IR_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: default parameters ----------------
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [1:0]    cmd_ir = '0;
    logic [DR-1:0] cmd_data = '0;
    logic          rsp_valid, rsp_ready = 1'b0;
    logic [DR-1:0] rsp_data;
    logic          vji_tck, vji_tdi, vji_tdo;
    logic [1:0]    vji_ir_in;
    logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    accel_sketch_nios2_gen2_0_cpu_debug_host #(
        .DR_WIDTH(DR), .IR_WIDTH(2), .TCK_DIV(TCK_DIV_A), .RTI_CYCLES(RTI_A)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    // ---------------- DUT B: TCK_DIV=1, RTI_CYCLES=0 ----------------
    logic          cmd_valid_b = 1'b0, cmd_ready_b;
    logic [1:0]    cmd_ir_b = '0;
    logic [DR-1:0] cmd_data_b = '0;
    logic          rsp_valid_b, rsp_ready_b = 1'b0;
    logic [DR-1:0] rsp_data_b;
    logic          tck_b, tdi_b, tdo_b;
    logic [1:0]    ir_in_b;
    logic          uir_b, cdr_b, sdr_b, udr_b, rti_b;

    accel_sketch_nios2_gen2_0_cpu_debug_host #(
        .DR_WIDTH(DR), .IR_WIDTH(2), .TCK_DIV(TCK_DIV_B), .RTI_CYCLES(RTI_B)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_ir(cmd_ir_b), .cmd_data(cmd_data_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b),
        .vji_tck(tck_b), .vji_tdi(tdi_b), .vji_tdo(tdo_b), .vji_ir_in(ir_in_b),
        .vji_uir(uir_b), .vji_cdr(cdr_b), .vji_sdr(sdr_b), .vji_udr(udr_b), .vji_rti(rti_b)
    );

    // ---------------- loopback slave models (DR-bit shift register) ----------------
    logic [DR-1:0] slave_sr, slave_preload = '0;
    logic          slave_load = 1'b0;
    assign vji_tdo = slave_sr[0];
    always @(posedge vji_tck or posedge slave_load) begin
        if (slave_load)   slave_sr <= slave_preload;
        else if (vji_sdr) slave_sr <= {vji_tdi, slave_sr[DR-1:1]};
    end

    logic [DR-1:0] slave_b_sr, slave_b_preload = '0;
    logic          slave_b_load = 1'b0;
    assign tdo_b = slave_b_sr[0];
    always @(posedge tck_b or posedge slave_b_load) begin
        if (slave_b_load) slave_b_sr <= slave_b_preload;
        else if (sdr_b)   slave_b_sr <= {tdi_b, slave_b_sr[DR-1:1]};
    end

    // ---------------- tck observers (running totals, never cleared) ----------------
    int   rises_cnt = 0, uir_cnt = 0, cdr_cnt = 0, sdr_cnt = 0, udr_cnt = 0, rti_cnt = 0;
    logic [1:0] uir_ir_seen = '0;
    time  last_rise_t = 0, tck_period = 0;
    always @(posedge vji_tck) begin
        rises_cnt   <= rises_cnt + 1;
        uir_cnt     <= uir_cnt + int'(vji_uir);
        cdr_cnt     <= cdr_cnt + int'(vji_cdr);
        sdr_cnt     <= sdr_cnt + int'(vji_sdr);
        udr_cnt     <= udr_cnt + int'(vji_udr);
        rti_cnt     <= rti_cnt + int'(vji_rti);
        if (vji_uir) uir_ir_seen <= vji_ir_in;
        tck_period  <= $time - last_rise_t;
        last_rise_t <= $time;
    end

    int  rises_b = 0, rti_cnt_b = 0;
    time last_rise_b = 0, tck_period_b = 0;
    always @(posedge tck_b) begin
        rises_b      <= rises_b + 1;
        rti_cnt_b    <= rti_cnt_b + int'(rti_b);
        tck_period_b <= $time - last_rise_b;
        last_rise_b  <= $time;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    bit         ir_known = 1'b0;   // slave holds a loaded IR (cleared by reset)
    logic [1:0] last_ir = '0;
    bit         cur_uir;
    int         snap_rises, snap_uir, snap_cdr, snap_sdr, snap_udr, snap_rti;
    int         txn_no = 0;

    function automatic bit expect_uir(input logic [1:0] ir);
        return !(SKIP_EN && ir_known && (ir == last_ir));
    endfunction

    task automatic load_slave(input logic [DR-1:0] v);
        slave_preload = v;
        slave_load = 1'b1;
        #1;
        slave_load = 1'b0;
    endtask

    // Present a command at a negedge; returns #1 after the accept edge.
    task automatic issue(input logic [1:0] ir, input logic [DR-1:0] data);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ir    = ir;
        cmd_data  = data;
        check("ready_idle", 64'(cmd_ready), 64'(1));
        check("tck_idle", 64'(vji_tck), 64'(0));
        cur_uir    = expect_uir(ir);
        snap_rises = rises_cnt; snap_uir = uir_cnt; snap_cdr = cdr_cnt;
        snap_sdr   = sdr_cnt;   snap_udr = udr_cnt; snap_rti = rti_cnt;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = DR'({$urandom(), $urandom()});   // late changes must not matter
        check("accepted", 64'(cmd_ready), 64'(0));
    endtask

    // Wait for the response, check it, hold it for 'hold' cycles, then consume it.
    // With b2b set, the next command is offered during the hold.
    task automatic finish(input logic [1:0] ir, input logic [DR-1:0] data,
                          input logic [DR-1:0] exp_rsp, input int hold, input bit b2b,
                          input logic [1:0] nir, input logic [DR-1:0] ndata);
        int lat;
        int exp_lat;
        bit stable;
        logic [DR-1:0] held;
        lat = 0;
        stable = 1'b1;
        exp_lat = (2 + int'(cur_uir) + DR + RTI_A) * 2 * TCK_DIV_A;
        while (!rsp_valid && lat < LAT_LIMIT) begin
            cmd_valid = 1'($urandom_range(0, 1));   // ignored outside IDLE
            cmd_ir    = 2'($urandom());
            cmd_data  = DR'({$urandom(), $urandom()});
            @(posedge clk);
            #1;
            lat++;
        end
        cmd_valid = 1'b0;
        check("latency", 64'(lat), 64'(exp_lat));
        check("rsp_data", 64'(rsp_data), 64'(exp_rsp));
        check("slave_sr", 64'(slave_sr), 64'(data));
        check("n_uir", 64'(uir_cnt - snap_uir), 64'(cur_uir));
        check("n_cdr", 64'(cdr_cnt - snap_cdr), 64'(1));
        check("n_sdr", 64'(sdr_cnt - snap_sdr), 64'(DR));
        check("n_udr", 64'(udr_cnt - snap_udr), 64'(1));
        check("n_rti", 64'(rti_cnt - snap_rti), 64'(RTI_A));
        check("n_rises", 64'(rises_cnt - snap_rises), 64'(2 + int'(cur_uir) + DR + RTI_A));
        check("tck_period", 64'(tck_period), 64'(2 * TCK_DIV_A * CLK_NS));
        if (cur_uir) check("ir_at_uir", 64'(uir_ir_seen), 64'(ir));
        check("ir_in", 64'(vji_ir_in), 64'(ir));
        check("tck_rsp", 64'(vji_tck), 64'(0));
        check("ready_rsp", 64'(cmd_ready), 64'(0));
        held = rsp_data;
        if (b2b) begin
            cmd_valid = 1'b1;
            cmd_ir    = nir;
            cmd_data  = ndata;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (!rsp_valid || (rsp_data !== held) || cmd_ready) stable = 1'b0;
        end
        check("rsp_hold", 64'(stable), 64'(1));
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_drop", 64'(rsp_valid), 64'(0));
        check("ready_back", 64'(cmd_ready), 64'(1));
        ir_known = 1'b1;
        last_ir  = ir;
        txn_no++;
        $display("txn %0d ir=%0d data=%h rsp=%h lat=%0d uir=%0d", txn_no, ir, data, rsp_data, lat, cur_uir);
    endtask

    // Global watchdog
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]    ir;
        logic [DR-1:0] d, d2, p;
        int            lat_b, guard;

        // ---- reset ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(cmd_ready), 64'(1));
        check("rst_outs", 64'({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, rsp_valid}), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        check("rst_ir_in", 64'(vji_ir_in), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_ready", 64'(cmd_ready), 64'(1));
        check("idle_tck", 64'(vji_tck), 64'(0));

        // ---- directed vector ----
        load_slave(38'h15_0F0F_0F0F);
        issue(IR_BREAK, 38'h2A_5555_5555);
        finish(IR_BREAK, 38'h2A_5555_5555, 38'h15_0F0F_0F0F, 2, 1'b0, 2'b00, '0);

        // ---- long hold with back-to-back command, then repeated / changed IR ----
        d  = DR'({$urandom(), $urandom()});
        d2 = DR'({$urandom(), $urandom()});
        p  = DR'({$urandom(), $urandom()});
        load_slave(p);
        issue(IR_OCIMEM, d);
        finish(IR_OCIMEM, d, p, 20, 1'b1, IR_OCIMEM, d2);
        issue(IR_OCIMEM, d2);                      // accepted the edge after the handshake
        finish(IR_OCIMEM, d2, d, 1, 1'b0, 2'b00, '0);   // loopback returns previous word
        d = DR'({$urandom(), $urandom()});
        issue(IR_TRACEMEM, d);
        finish(IR_TRACEMEM, d, d2, 0, 1'b0, 2'b00, '0);

        // ---- randomized commands ----
        for (int t = 0; t < 6; t++) begin
            ir = 2'($urandom_range(0, 3));
            d  = DR'({$urandom(), $urandom()});
            p  = DR'({$urandom(), $urandom()});
            load_slave(p);
            issue(ir, d);
            finish(ir, d, p, $urandom_range(0, 3), 1'b0, 2'b00, '0);
        end

        // ---- reset in the middle of SDR ----
        d = DR'({$urandom(), $urandom()});
        load_slave(DR'({$urandom(), $urandom()}));
        issue(IR_TRACECTRL, d);
        guard = 0;
        while ((sdr_cnt - snap_sdr) < 17 && guard < LAT_LIMIT) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("reach_bit17", 64'(guard < LAT_LIMIT), 64'(1));
        check("in_sdr", 64'(vji_sdr), 64'(1));
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_outs", 64'({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, rsp_valid}), 64'(0));
        check("arst_rsp_data", 64'(rsp_data), 64'(0));
        check("arst_ir_in", 64'(vji_ir_in), 64'(0));
        check("arst_ready", 64'(cmd_ready), 64'(1));
        @(negedge clk);
        reset_n  = 1'b1;
        ir_known = 1'b0;
        d = DR'({$urandom(), $urandom()});
        p = DR'({$urandom(), $urandom()});
        load_slave(p);
        issue(IR_TRACECTRL, d);
        finish(IR_TRACECTRL, d, p, 1, 1'b0, 2'b00, '0);

        // ---- DUT B: TCK_DIV=1, RTI_CYCLES=0 ----
        d = DR'({$urandom(), $urandom()});
        p = DR'({$urandom(), $urandom()});
        slave_b_preload = p;
        slave_b_load = 1'b1;
        #1;
        slave_b_load = 1'b0;
        @(negedge clk);
        cmd_valid_b = 1'b1;
        cmd_ir_b    = IR_BREAK;
        cmd_data_b  = d;
        check("b_ready_idle", 64'(cmd_ready_b), 64'(1));
        snap_rises = rises_b;
        snap_rti   = rti_cnt_b;
        @(posedge clk);
        #1;
        cmd_valid_b = 1'b0;
        lat_b = 0;
        while (!rsp_valid_b && lat_b < LAT_LIMIT) begin
            @(posedge clk);
            #1;
            lat_b++;
        end
        check("b_latency", 64'(lat_b), 64'((3 + DR + RTI_B) * 2 * TCK_DIV_B));
        check("b_rsp_data", 64'(rsp_data_b), 64'(p));
        check("b_slave_sr", 64'(slave_b_sr), 64'(d));
        check("b_n_rti", 64'(rti_cnt_b - snap_rti), 64'(0));
        check("b_n_rises", 64'(rises_b - snap_rises), 64'(3 + DR + RTI_B));
        check("b_tck_period", 64'(tck_period_b), 64'(2 * TCK_DIV_B * CLK_NS));
        check("b_ir_in", 64'(ir_in_b), 64'(IR_BREAK));
        @(negedge clk);
        rsp_ready_b = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_b = 1'b0;
        check("b_rsp_drop", 64'(rsp_valid_b), 64'(0));
        check("b_ready_back", 64'(cmd_ready_b), 64'(1));
        txn_no++;
        $display("txn %0d (tck_div=1) ir=%0d data=%h rsp=%h lat=%0d", txn_no, IR_BREAK, d, rsp_data_b, lat_b);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/accel_sketch_nios2_gen2_0_cpu_debug_host.md
Name: accel_sketch_nios2_gen2_0_cpu_debug_host

Overview:
- Initiator end of the Nios II virtual-JTAG debug channel.
- Turns a parallel command (IR code plus DR word) into a virtual JTAG sequence: tck, tdi, ir_in and the uir/cdr/sdr/udr/rti strobes.
- Captures tdo into a parallel response word.
- Sits on the clk domain of the system-level debug harness.
- Drives the CPU debug slave's virtual JTAG inputs directly, with no sld hub, so debug transactions can be driven on-chip and in simulation.

Parameters:
- DR_WIDTH, 38: data register length shifted per command.
- IR_WIDTH, 2: virtual IR width.
- TCK_DIV, 2: clk cycles per tck half-period; minimum 1.
- RTI_CYCLES, 2: tck periods spent in run-test-idle after update; 0 is legal and skips RTI.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_ir  in  IR_WIDTH  virtual IR value to load.
- cmd_data  in  DR_WIDTH  word to shift out, LSB first.
- rsp_valid  out  1  response held until accepted.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DR_WIDTH  tdo bits captured; bit i = i-th shifted bit.
- vji_tck  out  1  generated TCK.
- vji_tdi  out  1  serial data to slave.
- vji_tdo  in  1  serial data from slave.
- vji_ir_in  out  IR_WIDTH  virtual IR.
- vji_uir  out  1  update-IR strobe.
- vji_cdr  out  1  capture-DR strobe.
- vji_sdr  out  1  shift-DR strobe.
- vji_udr  out  1  update-DR strobe.
- vji_rti  out  1  run-test-idle.

Behaviour:
- Interface (already decided): one clock `clk`; reset `reset_n`, asynchronous and active-low.
- All outputs are registered.
- Reset values:
  - tck, tdi, all strobes, rsp_valid = 0.
  - ir_in = 0, rsp_data = 0.
  - cmd_ready = 1, state = IDLE.
- TCK generation:
  - Half-period counter runs 0..TCK_DIV-1 only outside IDLE/RSP.
  - tck toggles on terminal count.
  - One tck period = 2*TCK_DIV clk cycles, always starting low.
  - "rise" and "fall" are the clk edges at which tck toggles.
- States: IDLE, UIR, CDR, SDR, UDR, RTI, RSP.
  - Every active state lasts whole tck periods.
  - Strobes are 1 exactly while in the matching state.
- IDLE: on cmd_valid && cmd_ready, latch cmd_ir and cmd_data, then go to UIR. vji_ir_in takes cmd_ir on that same edge and holds until the next accept.
- UIR → CDR → SDR: one tck period each.
- SDR: DR_WIDTH periods.
  - tdi = shift[0] from the period start.
  - At each rise, sample vji_tdo into bit i.
  - At period end, shift the tx register right.
- SDR → UDR (1 period) → RTI (RTI_CYCLES periods, vji_rti=1) → RSP.
- RSP: rsp_valid=1 with rsp_data stable. On rsp_ready, go to IDLE on the next edge. cmd_ready=0 throughout RSP.
- Latency: rsp_valid rises exactly (3+DR_WIDTH+RTI_CYCLES)*2*TCK_DIV clk edges after the accept edge. Defaults give 172.
- cmd_valid outside IDLE is ignored; no queueing.
- cmd_data changes after accept have no effect.
- A back-to-back command is accepted no earlier than the edge after the rsp handshake.
- tck is 0 in IDLE and RSP, and 0 at every state boundary.
- Reset asserted mid-operation returns everything immediately to reset values. The partial response is discarded.
- Counter widths: $clog2 of TCK_DIV and DR_WIDTH. No wrap is ever reachable beyond the terminal values.

Optional Feature:
- Macro: DEBUG_HOST_IR_SKIP_EN.
- When defined:
  - A "last_ir_valid" flag is cleared by reset and set on leaving UIR.
  - If at accept cmd_ir == vji_ir_in and last_ir_valid, UIR is skipped (IDLE→CDR).
  - Latency is reduced by 2*TCK_DIV.
- When undefined: every command passes through UIR; no flag register exists.

Decomposition:
- Package accel_sketch_debug_host_pkg holds:
  - State enum.
  - IR code constants: OCIMEM=2'b00, TRACEMEM=2'b01, BREAK=2'b10, TRACECTRL=2'b11.
  - Default DR width 38.
- Sub-module accel_sketch_debug_host_tck_gen provides the half-period counter, tck, and rise/fall pulses, with an enable input.

Test Plan:
- Reset then cmd_ir=2'b10, cmd_data=38'h2A_5555_5555 with a tdo loopback model (38-bit sr) preloaded with 38'h15_0F0F_0F0F → rsp_data=38'h15_0F0F_0F0F, loopback sr=38'h2A_5555_5555, rsp_valid at edge 172.
- Strobe check, defaults: exactly 1 uir, 1 cdr, 38 sdr, 1 udr, 2 rti tck periods; 43 tck rises; ir_in=2'b10 at the first uir rise.
- TCK_DIV=1, RTI_CYCLES=0: rsp_valid at edge 82; tck period = 2 clk.
- Hold rsp_ready=0 for 20 cycles → rsp_valid and rsp_data stable, cmd_ready=0, cmd_valid ignored; accepted 1 edge after the handshake.
- Assert reset_n=0 in SDR at bit 17 → all outputs zero asynchronously; the next command after release completes normally with the correct data.
- With DEBUG_HOST_IR_SKIP_EN: two commands with ir=2'b00 → the second has no uir and rsp_valid at edge 168; a third with ir=2'b01 has uir and edge 172.
